// File: rtl/word_unpack_pkg.sv
// Shared types and helpers for the word-to-byte unpacker and its sibling packers.
package word_unpack_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Width of a byte-count field able to hold the value N (N = word_w/byte_w).
    function automatic int nb_width(input int word_w, input int byte_w);
        return $clog2(word_w / byte_w) + 1;
    endfunction

    // A requested count of 0, or anything above N, means "the whole word".
    function automatic int unsigned nbytes_eff(input int unsigned nbytes, input int unsigned n);
        return ((nbytes == 0) || (nbytes > n)) ? n : nbytes;
    endfunction

endpackage

// File: rtl/byte_part_sel.sv
// Combinational byte selector: picks symbol idx_i out of hold_i, ascending from
// bit 0 or descending from the top bit depending on MSB_FIRST.
module byte_part_sel #(
    parameter int WORD_W    = 256,
    parameter int BYTE_W    = 8,
    parameter int MSB_FIRST = 0,
    parameter int IDX_W     = 5
) (
    input  logic [WORD_W-1:0] hold_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [BYTE_W-1:0] byte_o
);

    localparam int OFF_W = $clog2(WORD_W);

    logic [OFF_W-1:0] off;

    always_comb begin
        off = OFF_W'(idx_i) * OFF_W'(BYTE_W);
    end

    generate
        if (MSB_FIRST != 0) begin : g_msb
            always_comb begin
                byte_o = hold_i[OFF_W'(WORD_W - 1) - off -: BYTE_W];
            end
        end else begin : g_lsb
            always_comb begin
                byte_o = hold_i[off +: BYTE_W];
            end
        end
    endgenerate

endmodule

// File: rtl/word_byte_unpacker.sv
// Accepts one wide word per valid/ready handshake and streams its bytes out one per cycle.
// Define WORD_UNPACK_PARITY_EN to add out_parity (XOR of out_data, aligned with it).
module word_byte_unpacker
    import word_unpack_pkg::*;
#(
    parameter int WORD_W    = 256,
    parameter int BYTE_W    = 8,
    parameter int MSB_FIRST = 0,
    parameter int NB_W      = nb_width(WORD_W, BYTE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [NB_W-1:0]   in_nbytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last
`ifdef WORD_UNPACK_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int unsigned N     = WORD_W / BYTE_W;
    localparam int          IDX_W = (N > 1) ? $clog2(N) : 1;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  hold_q, hold_d;
    logic [NB_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]  sel_byte;
    logic               is_last;
    logic               load;

    byte_part_sel #(
        .WORD_W    (WORD_W),
        .BYTE_W    (BYTE_W),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_sel (
        .hold_i (hold_q),
        .idx_i  (idx_q),
        .byte_o (sel_byte)
    );

    assign is_last = (state_q == EMIT) && (NB_W'(idx_q) == (cnt_q - NB_W'(1)));

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (!is_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        // Final byte leaving: take the next word in the same cycle, no bubble.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            hold_d  = in_data;
            cnt_d   = NB_W'(nbytes_eff(32'(in_nbytes), N));
            idx_d   = '0;
            state_d = EMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs are zero whenever no byte is being offered.
    assign out_data = (state_q == EMIT) ? sel_byte : '0;
    assign out_last = is_last;

`ifdef WORD_UNPACK_PARITY_EN
    assign out_parity = ^out_data;
`else
    // Parity output is not built in this configuration.
`endif

endmodule

// File: tb/tb_word_byte_unpacker.sv
// Directed self-checking bench: an LSB-first and an MSB-first instance share stimulus;
// with WORD_UNPACK_PARITY_EN defined, a 64-bit instance also checks out_parity.
module tb_word_byte_unpacker;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [255:0] in_data;
    logic [5:0]   in_nbytes;
    logic         out_ready;

    logic       in_ready_l, out_valid_l, out_last_l;
    logic [7:0] out_data_l;
    logic       in_ready_m, out_valid_m, out_last_m;
    logic [7:0] out_data_m;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef WORD_UNPACK_PARITY_EN
    logic par_l, par_m;
`endif

    word_byte_unpacker #(.WORD_W(256), .BYTE_W(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .in_nbytes(in_nbytes),
        .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .out_last(out_last_l)
`ifdef WORD_UNPACK_PARITY_EN
        , .out_parity(par_l)
`endif
    );

    word_byte_unpacker #(.WORD_W(256), .BYTE_W(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_m),
        .in_data(in_data), .in_nbytes(in_nbytes),
        .out_valid(out_valid_m), .out_ready(out_ready),
        .out_data(out_data_m), .out_last(out_last_m)
`ifdef WORD_UNPACK_PARITY_EN
        , .out_parity(par_m)
`endif
    );

`ifdef WORD_UNPACK_PARITY_EN
    logic        p_valid, p_ready_in, p_out_valid, p_last, p_par, p_ready;
    logic [63:0] p_data;
    logic [3:0]  p_nbytes;
    logic [7:0]  p_byte;

    word_byte_unpacker #(.WORD_W(64), .BYTE_W(8), .MSB_FIRST(0)) dut_par (
        .clk(clk), .rst(rst),
        .in_valid(p_valid), .in_ready(p_ready_in),
        .in_data(p_data), .in_nbytes(p_nbytes),
        .out_valid(p_out_valid), .out_ready(p_ready),
        .out_data(p_byte), .out_last(p_last),
        .out_parity(p_par)
    );
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [255:0] mk_word(input logic [7:0] base);
        logic [255:0] w;
        for (int k = 0; k < 32; k++) w[8*k +: 8] = 8'(int'(base) + k);
        return w;
    endfunction

    task automatic chk_byte(input string tag, input int k, input logic [7:0] exp_l,
                            input logic [7:0] exp_m, input logic exp_last);
        check($sformatf("%s_b%0d_valid", tag, k), {out_valid_l, out_valid_m}, 2'b11);
        check($sformatf("%s_b%0d_lsb", tag, k), out_data_l, exp_l);
        check($sformatf("%s_b%0d_msb", tag, k), out_data_m, exp_m);
        check($sformatf("%s_b%0d_last", tag, k), {out_last_l, out_last_m}, {exp_last, exp_last});
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_idle_valid"}, {out_valid_l, out_valid_m}, 2'b00);
        check({tag, "_idle_ready"}, {in_ready_l, in_ready_m}, 2'b11);
    endtask

    // Present one word at the current negedge and drain count bytes with out_ready=1.
    task automatic run_word(input string tag, input logic [7:0] base, input logic [5:0] nb,
                            input int count);
        in_valid  = 1'b1;
        in_data   = mk_word(base);
        in_nbytes = nb;
        out_ready = 1'b1;
        check({tag, "_hs_ready"}, in_ready_l, 1'b1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < count; k++) begin
            chk_byte(tag, k, 8'(int'(base) + k), 8'(int'(base) + 31 - k), k == count - 1);
            step();
        end
        chk_idle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] pat;
        int         idx;
        int         xfers;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_nbytes = '0;
        out_ready = 1'b0;
`ifdef WORD_UNPACK_PARITY_EN
        p_valid  = 1'b0;
        p_data   = '0;
        p_nbytes = '0;
        p_ready  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_valid", {out_valid_l, out_valid_m}, 2'b00);
        check("rst_last", {out_last_l, out_last_m}, 2'b00);
        check("rst_ready", {in_ready_l, in_ready_m}, 2'b11);
        check("rst_data", {out_data_l, out_data_m}, 16'h0000);
        rst = 1'b0;

        // Full word, nbytes=0 clamps to 32; MSB instance sees 0x1F..0x00
        run_word("t1", 8'h00, 6'd0, 32);

        // Four bytes: MSB instance emits 1F,1E,1D,1C
        run_word("t2", 8'h00, 6'd4, 4);

        // Backpressure: out_ready 1,0,0,1,1 over three bytes
        pat       = 5'b11001;
        in_valid  = 1'b1;
        in_data   = mk_word(8'h40);
        in_nbytes = 6'd3;
        step();
        in_valid = 1'b0;
        idx      = 0;
        xfers    = 0;
        for (int c = 0; c < 5; c++) begin
            out_ready = pat[c];
            chk_byte("t3", c, 8'(8'h40 + idx), 8'(8'h5F - idx), idx == 2);
            if (pat[c]) begin
                idx++;
                xfers++;
            end
            step();
        end
        check("t3_xfers", 64'(xfers), 64'd3);
        chk_idle("t3");

        // Back-to-back: A (2 bytes) then B (1 byte), in_valid held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = mk_word(8'h10);
        in_nbytes = 6'd2;
        step();
        in_data   = mk_word(8'h60);
        in_nbytes = 6'd1;
        chk_byte("t4A", 0, 8'h10, 8'h2F, 1'b0);
        check("t4_ready_mid", in_ready_l, 1'b0);
        step();
        chk_byte("t4A", 1, 8'h11, 8'h2E, 1'b1);
        check("t4_ready_last", in_ready_l, 1'b1);
        step();
        in_valid = 1'b0;
        chk_byte("t4B", 0, 8'h60, 8'h7F, 1'b1);
        step();
        chk_idle("t4");

        // Clamp: nbytes=40 behaves as 32
        run_word("t5a", 8'h80, 6'd40, 32);

        // Reset after byte 5 of a second word
        in_valid  = 1'b1;
        in_data   = mk_word(8'hC0);
        in_nbytes = 6'd0;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk_byte("t5b", k, 8'(8'hC0 + k), 8'(8'hDF - k), 1'b0);
            if (k == 5) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        check("t5b_rst_valid", {out_valid_l, out_valid_m}, 2'b00);
        check("t5b_rst_ready", {in_ready_l, in_ready_m}, 2'b11);
        check("t5b_rst_data", {out_data_l, out_data_m}, 16'h0000);
        check("t5b_rst_last", {out_last_l, out_last_m}, 2'b00);
        run_word("t5c", 8'h20, 6'd2, 2);

`ifdef WORD_UNPACK_PARITY_EN
        begin
            logic [31:0] pbytes;
            logic [3:0]  ppar;
            pbytes   = 32'h80FF_0301;
            ppar     = 4'b1001;
            p_valid  = 1'b1;
            p_data   = {32'h0, pbytes};
            p_nbytes = 4'd4;
            p_ready  = 1'b1;
            step();
            p_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("par_b%0d_data", k), p_byte, pbytes[8*k +: 8]);
                check($sformatf("par_b%0d_par", k), p_par, ppar[k]);
                check($sformatf("par_b%0d_last", k), p_last, k == 3);
                step();
            end
            check("par_idle_valid", p_out_valid, 1'b0);
            check("par_idle_parity", p_par, 1'b0);
            check("par_idle_ready", p_ready_in, 1'b1);
            check("par_lsb_256", par_l, 1'b0);
            check("par_msb_256", par_m, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/word_byte_unpacker.md
Name: word_byte_unpacker

Overview:
- Downstream byte-extraction stage for wide registers.
- Accepts one WORD_W-bit word over a valid/ready handshake and emits its bytes one per cycle on a byte stream.
- Bytes are selected with indexed part-selects: ascending from bit 0, or descending from the top bit.
- Sits between wide-word producers (256-bit data registers) and byte-wide consumers.

Parameters:
- WORD_W, 256, input word width; must be a multiple of BYTE_W.
- BYTE_W, 8, output symbol width.
- MSB_FIRST, 0
  - 0: byte k = word[k*BYTE_W +: BYTE_W]
  - 1: byte k = word[WORD_W-1-k*BYTE_W -: BYTE_W]

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  word available.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WORD_W  word to unpack.
- in_nbytes  input  NB_W  number of bytes to emit.
  - NB_W = $clog2(WORD_W/BYTE_W)+1.
  - 0 or any value > N means N, where N = WORD_W/BYTE_W.
- out_valid  output  1  byte available.
- out_ready  input  1  consumer takes the byte.
- out_data  output  BYTE_W  current byte.
- out_last  output  1  current byte is the final byte of the word.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) forces:
  - state=IDLE, in_ready=1 (combinational from state), out_valid=0, out_last=0.
  - out_data=0, byte index=0, holding register=0.
- Reset mid-word discards the remaining bytes; no partial output after reset.
- States:
  - IDLE: out_valid=0, in_ready=1.
    - in_valid=1 loads hold<=in_data, cnt<=effective nbytes, idx<=0, then goes to EMIT.
  - EMIT: out_valid=1.
    - out_data = selected byte of hold at idx (registered or combinational from registers; no dependence on in_data).
    - out_last = (idx==cnt-1).
    - out_ready=1 and !out_last: idx<=idx+1.
    - out_ready=1 and out_last: word complete. If in_valid=1 in the same cycle, load the new word and stay in EMIT with idx=0; otherwise go to IDLE.
- in_ready = IDLE || (EMIT && out_ready && out_last). This gives back-to-back words with no bubble.
- Latency:
  - word accepted at edge t → first byte valid after edge t (cycle t+1).
  - Throughput is one byte per cycle under continuous out_ready.
- Stall: out_ready=0 holds out_data, out_last, idx and hold stable. out_valid never drops while in EMIT.
- nbytes boundaries:
  - 1 → a single byte with out_last=1.
  - N → the full word.
  - 0 or >N → clamped to N.
- idx never exceeds cnt-1. The upper-bound wrap (idx=N-1) is exercised by the full-word case.
- in_data and in_nbytes are sampled only on the in_valid && in_ready handshake.

Optional Feature:
- Macro WORD_UNPACK_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR-reduction of out_data, aligned with out_data.
  - Reset value 0.
- Undefined: port absent; no parity logic.

Decomposition:
- Package word_unpack_pkg holds:
  - state enum type (IDLE, EMIT).
  - localparam-style function nbytes_eff(nbytes, N) for clamping.
  - function nb_width(WORD_W, BYTE_W).
- One natural sub-module, byte_part_sel: combinational; ports hold, idx → byte; MSB_FIRST selects +: or -: part-select. It is reusable by sibling packers.

Test Plan:
- Basic, LSB-first: WORD_W=256, MSB_FIRST=0, in_data with byte k = k, nbytes=0, out_ready=1.
  - 32 bytes 0x00..0x1F on consecutive cycles.
  - out_last only on 0x1F.
  - First byte one cycle after the handshake.
- MSB-first: MSB_FIRST=1, same word, nbytes=4.
  - Bytes 0x1F, 0x1E, 0x1D, 0x1C; out_last on 0x1C.
  - Then IDLE with in_ready=1.
- Backpressure: nbytes=3, out_ready toggled 1,0,0,1,1.
  - Each byte held stable through the stall.
  - Exactly 3 transfers; no duplicates or drops.
- Back-to-back words: word A (nbytes=2) and word B (nbytes=1), in_valid held high.
  - B accepted on A's last-byte handshake.
  - Output A0, A1, B0 on 3 consecutive cycles.
- Clamp and reset: nbytes=40 → 32 bytes emitted.
  - In a second word, assert rst after byte 5: next cycle out_valid=0, in_ready=1, out_data=0.
  - A fresh word then restarts at byte 0.
- Parity (WORD_W=64, WORD_UNPACK_PARITY_EN defined): bytes 0x01, 0x03, 0xFF, 0x80 → out_parity 1, 0, 0, 1.
